// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, sample-index helpers and tick divider constants for uart_rx_os
package uart_rx_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_START  = 3'd1;
    localparam logic [2:0] ENC_DATA   = 3'd2;
    localparam logic [2:0] ENC_PARITY = 3'd3;
    localparam logic [2:0] ENC_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_START  = ENC_START,
        ST_DATA   = ENC_DATA,
        ST_PARITY = ENC_PARITY,
        ST_STOP   = ENC_STOP
    } rx_state_t;

    // clk cycles per oversample tick at 12 MHz with 8 ticks per bit
    localparam int TICK_DIV_115200 = 13;
    localparam int TICK_DIV_57600  = 26;
    localparam int TICK_DIV_9600   = 156;

    function automatic int smp_first(input int ovs);
        return ovs / 2 - 1;
    endfunction

    function automatic int smp_mid(input int ovs);
        return ovs / 2;
    endfunction

    function automatic int smp_last(input int ovs);
        return ovs / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - clearable divider producing a one-cycle oversample tick every TICK_DIV clocks
module uart_os_tick #(
    parameter int TICK_DIV = 13
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver, 3-sample majority vote, ready/valid output; parity via UART_RX_PARITY_EN
module uart_rx_os
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 8,
    parameter int TICK_DIV   = TICK_DIV_115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 brk,
    output logic                 overrun
);

    localparam int OSW = $clog2(OVS) + 1;
    localparam logic [OSW-1:0] IDX_A    = OSW'(smp_first(OVS));
    localparam logic [OSW-1:0] IDX_B    = OSW'(smp_mid(OVS));
    localparam logic [OSW-1:0] IDX_C    = OSW'(smp_last(OVS));
    localparam logic [OSW-1:0] IDX_WRAP = OSW'(OVS);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic rx_m, rx_s;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    rx_state_t state, state_n;
    logic [OSW-1:0]       os_cnt, os_cnt_n, idx;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [1:0]           smp, smp_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 fe_acc, fe_acc_n;
    logic                 stop0, stop0_n, fst;
    logic                 par_bit, par_bit_n;
    logic                 tick, decide, maj;
    logic                 commit, c_fe, c_pe, c_brk;

    uart_os_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    assign idx    = os_cnt + 1'b1;
    assign decide = tick && (idx == IDX_C);
    // the third sample is the live rx_s at the decision tick
    assign maj    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign fst    = (bit_cnt == '0) ? maj : stop0;

`ifndef UART_RX_PARITY_EN
    logic unused_par;
    assign unused_par = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            smp     <= 2'b11;
            shreg   <= '0;
            fe_acc  <= 1'b0;
            stop0   <= 1'b1;
            par_bit <= 1'b0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_cnt_n;
            bit_cnt <= bit_cnt_n;
            smp     <= smp_n;
            shreg   <= shreg_n;
            fe_acc  <= fe_acc_n;
            stop0   <= stop0_n;
            par_bit <= par_bit_n;
        end
    end

    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_cnt_n = bit_cnt;
        smp_n     = smp;
        shreg_n   = shreg;
        fe_acc_n  = fe_acc;
        stop0_n   = stop0;
        par_bit_n = par_bit;
        commit    = 1'b0;
        c_fe      = 1'b0;
        c_pe      = 1'b0;
        c_brk     = 1'b0;
        if (tick) begin
            os_cnt_n = (idx == IDX_WRAP) ? '0 : idx;
            if (idx == IDX_A) smp_n[0] = rx_s;
            if (idx == IDX_B) smp_n[1] = rx_s;
        end
        case (state)
            ST_IDLE: begin
                os_cnt_n  = '0;
                bit_cnt_n = '0;
                fe_acc_n  = 1'b0;
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                if (decide) state_n = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shreg_n   = {maj, shreg[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide) begin
                    par_bit_n = maj;
                    state_n   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (decide) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (!maj) fe_acc_n = 1'b1;
                    if (bit_cnt == '0) stop0_n = maj;
                    // leave at mid-stop so a following start edge is not missed
                    if (bit_cnt == LAST_STOP) begin
                        state_n = ST_IDLE;
                        commit  = 1'b1;
                        c_fe    = fe_acc | ~maj;
`ifdef UART_RX_PARITY_EN
                        c_brk = (shreg == '0) && !par_bit && !fst;
                        c_pe  = ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`else
                        c_brk = (shreg == '0) && !fst;
`endif
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            if (commit) begin
                if (!valid || ready) begin
                    data       <= shreg;
                    frame_err  <= c_fe;
                    parity_err <= c_pe;
                    brk        <= c_brk;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - self-checking bench for uart_rx_os: vector table, scoreboard and multi-cycle corner cases
module tb_uart_rx_os;
    import uart_rx_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam int DB = 7, SB = 2, PODD = 1, NPB = 1;
`else
    localparam int DB = 8, SB = 1, PODD = 0, NPB = 0;
`endif
    localparam int OVS = 8, TD = 13, BITC = OVS * TD;

    logic clk = 1'b0;
    logic rstn, rx, ready, valid, frame_err, parity_err, brk, overrun;
    logic [DB-1:0] data;

    uart_rx_os #(.DATA_BITS(DB), .OVS(OVS), .TICK_DIV(TD), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rstn(rstn), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .parity_err(parity_err), .brk(brk), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] d;
        logic       par;
        logic [1:0] stp;
        int         glitch;
        logic [8:0] exp_d;
        logic       fe, pe, bk;
    } vec_t;

    typedef struct {
        logic [8:0] d;
        logic       fe, pe, bk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, tx_start = 0;
    logic v_prev = 1'b0;
    int rise_cyc = -1, rise_cnt = 0, vrun = 0, last_run = 0, ovr_cnt = 0, ovr_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1 && !v_prev) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        if (valid === 1'b1) vrun++;
        else if (v_prev) begin
            last_run = vrun;
            vrun = 0;
        end
        v_prev = (valid === 1'b1);
        if (overrun === 1'b1) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            check("sb_pending", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("data", 32'(data), 32'(mon_e.d));
                check("frame_err", 32'(frame_err), 32'(mon_e.fe));
                check("parity_err", 32'(parity_err), 32'(mon_e.pe));
                check("brk", 32'(brk), 32'(mon_e.bk));
            end
        end
    end

    task automatic send_frame(input logic [8:0] d, input logic par, input logic [1:0] stp, input int glitch);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (NPB != 0) bits.push_back(par);
        for (int i = 0; i < SB; i++) bits.push_back(stp[i]);
        tx_start = cyc;
        foreach (bits[k]) begin
            for (int c = 0; c < BITC; c++) begin
                rx = (k == glitch && c >= 46 && c < 59) ? ~bits[k] : bits[k];
                @(posedge clk); #1;
            end
        end
        rx = 1'b1;
    endtask

    task automatic push_exp(input logic [8:0] d, input logic fe, input logic pe, input logic bk);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe; e.bk = bk;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("sb_drained", 32'(sb_q.size()), 0);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v.exp_d, v.fe, v.pe, v.bk);
        send_frame(v.d, v.par, v.stp, v.glitch);
        wait_drain(400);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_fe"}, 32'(frame_err), 0);
        check({tag, "_pe"}, 32'(parity_err), 0);
        check({tag, "_brk"}, 32'(brk), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rc0, oc0, tx2;
`ifdef UART_RX_PARITY_EN
        tbl.push_back('{9'h041, 1'b1, 2'b11, -1, 9'h041, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{9'h041, 1'b0, 2'b11, -1, 9'h041, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{9'h041, 1'b1, 2'b01, -1, 9'h041, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{9'h000, 1'b0, 2'b00, -1, 9'h000, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{9'h07F, 1'b0, 2'b11,  3, 9'h07F, 1'b0, 1'b0, 1'b0});
`else
        tbl.push_back('{9'h0A3, 1'b0, 2'b11,  3, 9'h0A3, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{9'h03C, 1'b0, 2'b00, -1, 9'h03C, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{9'h000, 1'b0, 2'b11, -1, 9'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{9'h0FF, 1'b0, 2'b11,  8, 9'h0FF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{9'h000, 1'b0, 2'b00, -1, 9'h000, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{9'h081, 1'b0, 2'b11, -1, 9'h081, 1'b0, 1'b0, 1'b0});
`endif
        rstn = 1'b0; rx = 1'b1; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

`ifndef UART_RX_PARITY_EN
        push_exp(9'h055, 1'b0, 1'b0, 1'b0);
        send_frame(9'h055, 1'b0, 2'b11, -1);
        wait_drain(400);
        check("basic_valid_cycle", 32'(rise_cyc), 32'(tx_start + 1004));
        check("basic_valid_width", 32'(last_run), 1);
`endif

        foreach (tbl[i]) run_vec(tbl[i]);

`ifndef UART_RX_PARITY_EN
        rc0 = rise_cnt;
        rx = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("glitch_no_valid", 32'(rise_cnt), 32'(rc0));
        check("glitch_idle", 32'(dut.state), 32'(ST_IDLE));

        // line held low ~12.6 bit times: the break frame, then one re-triggered frame
        push_exp(9'h000, 1'b1, 1'b0, 1'b1);
        push_exp(9'h0FC, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (1314) @(posedge clk);
        #1;
        rx = 1'b1;
        wait_drain(1500);

        ready = 1'b0;
        oc0 = ovr_cnt;
        push_exp(9'h011, 1'b0, 1'b0, 1'b0);
        send_frame(9'h011, 1'b0, 2'b11, -1);
        send_frame(9'h022, 1'b0, 2'b11, -1);
        tx2 = tx_start;
        repeat (20) @(posedge clk);
        #1;
        check("ovr_pulses", 32'(ovr_cnt - oc0), 1);
        check("ovr_cycle", 32'(ovr_cyc), 32'(tx2 + 1004));
        check("ovr_data_held", 32'(data), 32'h11);
        check("ovr_valid_held", 32'(valid), 1);
        ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ready_drops_valid", 32'(valid), 0);
        wait_drain(10);

        ready = 1'b0;
        send_frame(9'h05A, 1'b0, 2'b11, -1);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(valid), 1);
        check("pre_reset_data", 32'(data), 32'h5A);
        t0 = cyc;
        rc0 = rise_cnt;
        fork
            send_frame(9'h0F0, 1'b0, 2'b11, -1);
            begin
                repeat (587) begin
                    @(posedge clk); #1;
                end
                rstn = 1'b0;
                @(posedge clk); #1;
                check_zero_outputs("midreset");
                check("midreset_state", 32'(dut.state), 32'(ST_IDLE));
                rstn = 1'b1;
            end
        join
        ready = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        check("midreset_no_valid", 32'(rise_cnt), 32'(rc0));
        check("midreset_t0", 32'(t0 + 587 < cyc), 1);

        rc0 = rise_cnt;
        push_exp(9'h0F0, 1'b0, 1'b0, 1'b0);
        push_exp(9'h00F, 1'b0, 1'b0, 1'b0);
        send_frame(9'h0F0, 1'b0, 2'b11, -1);
        send_frame(9'h00F, 1'b0, 2'b11, -1);
        wait_drain(200);
        check("b2b_words", 32'(rise_cnt - rc0), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
